text_tokenizer: RTL

TEXT_TOKENIZER -- requirements
Module: text_tokenizer

---
 rtl/text_tokenizer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/text_tokenizer.sv
// Splits an ASCII character stream into upper-cased words with a length,
// a class (alpha/digit/mixed) and a truncation flag, one word per handshake.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   din/din_valid       : character stream in; din_ready accepts it
//   sdone               : end-of-text pulse from upstream
//   word_data/len/class : packed word, char count, 0 alpha 1 digit 2 mixed
//   word_trunc          : characters beyond MAXLEN were dropped
//   word_valid/ready    : word handshake
//   word_count          : words emitted since reset, saturating
//   tok_done            : all text processed and all words emitted
module text_tokenizer #(
   parameter int MAXLEN = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          din,
   input  logic                din_valid,
   output logic                din_ready,
   input  logic                sdone,
   output logic [8*MAXLEN-1:0] word_data,
   output logic [4:0]          word_len,
   output logic [1:0]          word_class,
   output logic                word_trunc,
   output logic                word_valid,
   input  logic                word_ready,
   output logic [7:0]          word_count,
   output logic                tok_done
);

   typedef enum logic [1:0] {
      COLLECT,
      EMIT,
      DONE
   } state_t;

   localparam logic [4:0] LMAX = 5'(MAXLEN);

   state_t              r_state;
   logic [8*MAXLEN-1:0] r_buf;
   logic [4:0]          r_len;
   logic [1:0]          r_class;
   logic                r_trunc;
   logic                r_valid;
   logic [7:0]          r_count;
   logic                r_tok_done;
   logic                r_pending;
   logic                r_din_ready;
   // running "every stored char so far is alpha / digit" flags
   logic                r_alpha;
   logic                r_digit;

   logic                w_acc;
   logic                w_delim;
   logic                w_lower;
   logic [7:0]          w_char;
   logic                w_is_alpha;
   logic                w_is_digit;
   logic                w_store;
   logic                w_drop;
   logic [4:0]          w_len_nxt;
   logic                w_alpha_nxt;
   logic                w_digit_nxt;
   logic [1:0]          w_class_nxt;
   logic                w_pend_nxt;
   logic                w_delim_word;
   logic                w_emit;
   logic                w_done;

   assign w_acc      = din_valid & r_din_ready;
   assign w_delim    = (din == 8'h20) | (din == 8'h0A) | (din == 8'h2E);
   assign w_lower    = (din >= 8'h61) & (din <= 8'h7A);
   assign w_char     = w_lower ? (din - 8'h20) : din;
   assign w_is_alpha = (w_char >= 8'h41) & (w_char <= 8'h5A);
   assign w_is_digit = (w_char >= 8'h30) & (w_char <= 8'h39);

   assign w_store = w_acc & ~w_delim & (r_len < LMAX);
   assign w_drop  = w_acc & ~w_delim & (r_len >= LMAX);

   // word state as it will be after this cycle's character
   assign w_len_nxt   = w_store ? (r_len + 5'd1) : r_len;
   assign w_alpha_nxt = r_alpha & (~w_store | w_is_alpha);
   assign w_digit_nxt = r_digit & (~w_store | w_is_digit);
   assign w_class_nxt = w_alpha_nxt ? 2'd0 :
                        w_digit_nxt ? 2'd1 : 2'd2;

   // end-of-text seen this cycle is handled after the accepted char
   assign w_pend_nxt   = r_pending | sdone;
   assign w_delim_word = w_acc & w_delim & (r_len != 5'd0);
   assign w_emit       = w_delim_word |
                         (w_pend_nxt & (w_len_nxt != 5'd0));
   assign w_done       = w_pend_nxt & (w_len_nxt == 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= COLLECT;
         r_buf       <= '0;
         r_len       <= 5'd0;
         r_class     <= 2'd0;
         r_trunc     <= 1'b0;
         r_valid     <= 1'b0;
         r_count     <= 8'd0;
         r_tok_done  <= 1'b0;
         r_pending   <= 1'b0;
         r_din_ready <= 1'b1;
         r_alpha     <= 1'b1;
         r_digit     <= 1'b1;
      end else begin
         unique case (r_state)
            COLLECT: begin
               if (sdone) begin
                  r_pending <= 1'b1;
               end
               if (w_store) begin
                  for (int i = 0; i < MAXLEN; i++) begin
                     if (r_len == 5'(i)) begin
                        r_buf[8*i +: 8] <= w_char;
                     end
                  end
                  r_len   <= w_len_nxt;
                  r_alpha <= w_alpha_nxt;
                  r_digit <= w_digit_nxt;
               end
               if (w_drop) begin
                  r_trunc <= 1'b1;
               end
               if (w_emit) begin
                  r_state     <= EMIT;
                  r_valid     <= 1'b1;
                  r_class     <= w_class_nxt;
                  r_din_ready <= 1'b0;
               end else if (w_done) begin
                  r_state     <= DONE;
                  r_tok_done  <= 1'b1;
                  r_din_ready <= 1'b0;
               end
            end
            EMIT: begin
               if (word_ready) begin
                  r_buf   <= '0;
                  r_len   <= 5'd0;
                  r_class <= 2'd0;
                  r_trunc <= 1'b0;
                  r_alpha <= 1'b1;
                  r_digit <= 1'b1;
                  r_valid <= 1'b0;
                  if (r_count != 8'hFF) begin
                     r_count <= r_count + 8'd1;
                  end
                  if (r_pending) begin
                     r_state    <= DONE;
                     r_tok_done <= 1'b1;
                  end else begin
                     r_state     <= COLLECT;
                     r_din_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state <= COLLECT;
            end
         endcase
      end
   end

   assign din_ready  = r_din_ready;
   assign word_data  = r_buf;
   assign word_len   = r_len;
   assign word_class = r_class;
   assign word_trunc = r_trunc;
   assign word_valid = r_valid;
   assign word_count = r_count;
   assign tok_done   = r_tok_done;

endmodule
